// File: rtl/pulp_clk_gate_sequencer_if.sv
// Power-manager side of the clock-gate sequencer: level request, gap config, test override, per-domain enables.
// The master drives the request/config side; the sequencer (slave) drives the enables and the ack/busy status.
interface pulp_clk_gate_sequencer_if #(
    parameter int NUM_DOMAINS = 4,
    parameter int GAP_W       = 4
);
    logic                   req_i;
    logic [GAP_W-1:0]       cfg_gap_i;
    logic                   test_mode_i;
    logic [NUM_DOMAINS-1:0] clk_en_o;
    logic                   ack_o;
    logic                   busy_o;

    modport master (
        output req_i,
        output cfg_gap_i,
        output test_mode_i,
        input  clk_en_o,
        input  ack_o,
        input  busy_o
    );

    modport slave (
        input  req_i,
        input  cfg_gap_i,
        input  test_mode_i,
        output clk_en_o,
        output ack_o,
        output busy_o
    );
endinterface

// File: rtl/pulp_clk_gate_sequencer.sv
// Ramps gated-clock enables up (ascending) / down (descending) with G+1 cycles between steps; first step 1 cycle after req.
// Level req/ack, no backpressure; test_mode_i forces all enables on combinationally without touching the FSM.
module pulp_clk_gate_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int GAP_W       = 4
) (
    input logic                      clk_i,
    input logic                      rst_ni,
    pulp_clk_gate_sequencer_if.slave bus
);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_DOMAINS - 1);

    localparam logic [1:0] S_OFF  = 2'd0;
    localparam logic [1:0] S_UP   = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;
    localparam logic [1:0] S_DOWN = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [GAP_W-1:0]       cnt_q, cnt_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [NUM_DOMAINS-1:0] en_q, en_d;
    logic                   ack_q, busy_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        en_d    = en_q;
        unique case (state_q)
            S_OFF: begin
                if (bus.req_i) begin
                    state_d  = S_UP;
                    idx_d    = '0;
                    en_d[0]  = 1'b1;
                    gap_d    = bus.cfg_gap_i;
                    cnt_d    = bus.cfg_gap_i;
                end
            end
            S_UP: begin
                // An abort undoes the current step right away, then ramps down from there.
                if (!bus.req_i) begin
                    state_d     = S_DOWN;
                    en_d[idx_q] = 1'b0;
                    gap_d       = bus.cfg_gap_i;
                    cnt_d       = bus.cfg_gap_i;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - GAP_W'(1);
                end else if (idx_q != LAST) begin
                    idx_d       = idx_q + IDX_W'(1);
                    en_d[idx_d] = 1'b1;
                    cnt_d       = gap_q;
                end else begin
                    state_d = S_ON;
                end
            end
            S_ON: begin
                if (!bus.req_i) begin
                    state_d    = S_DOWN;
                    idx_d      = LAST;
                    en_d[LAST] = 1'b0;
                    gap_d      = bus.cfg_gap_i;
                    cnt_d      = bus.cfg_gap_i;
                end
            end
            default: begin
                // DOWN: idx points at the most recently cleared domain.
                if (bus.req_i) begin
                    state_d     = S_UP;
                    en_d[idx_q] = 1'b1;
                    gap_d       = bus.cfg_gap_i;
                    cnt_d       = bus.cfg_gap_i;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - GAP_W'(1);
                end else if (idx_q != '0) begin
                    idx_d       = idx_q - IDX_W'(1);
                    en_d[idx_d] = 1'b0;
                    cnt_d       = gap_q;
                end else begin
                    state_d = S_OFF;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            en_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            en_q    <= en_d;
            ack_q   <= (state_d == S_ON);
            busy_q  <= (state_d == S_UP) || (state_d == S_DOWN);
        end
    end

    assign bus.clk_en_o = en_q | {NUM_DOMAINS{bus.test_mode_i}};
    assign bus.ack_o    = ack_q;
    assign bus.busy_o   = busy_q;
endmodule

// File: tb/tb_pulp_clk_gate_sequencer.sv
// Bench for pulp_clk_gate_sequencer: vector table, hand-written abort/reversal/reset sequences, random run vs. domain-count model.
module tb_pulp_clk_gate_sequencer;
    localparam int N = 4;

    logic clk;
    logic rst_n;

    pulp_clk_gate_sequencer_if #(.NUM_DOMAINS(N), .GAP_W(4)) bus ();

    pulp_clk_gate_sequencer #(.NUM_DOMAINS(N), .GAP_W(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       req;
        logic [3:0] gap;
        logic       tm;
        logic [3:0] en;
        logic       ack;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference: number of enabled domains, ramp direction and a countdown to the next step.
    int m_on;
    int m_dir;
    int m_tmr;
    int m_gap;
    bit m_ramp;

    function automatic void add(input int n, input logic r, input logic [3:0] g, input logic t,
                                input logic [3:0] e, input logic a, input logic b);
        vec_t v;
        v = '{r, g, t, e, a, b};
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    function automatic void model_reset();
        m_on = 0; m_dir = 0; m_tmr = 0; m_gap = 0; m_ramp = 0;
    endfunction

    function automatic void model_edge(input logic r, input logic [3:0] g);
        int want;
        want = r ? 1 : -1;
        if ((m_ramp && m_dir != want) || (!m_ramp && (r ? (m_on != N) : (m_on != 0)))) begin
            m_ramp = 1; m_dir = want; m_on = m_on + want; m_gap = int'(g); m_tmr = int'(g);
        end else if (m_ramp) begin
            if (m_tmr > 0) m_tmr = m_tmr - 1;
            else if ((m_dir > 0 && m_on < N) || (m_dir < 0 && m_on > 0)) begin
                m_on = m_on + m_dir; m_tmr = m_gap;
            end else m_ramp = 0;
        end
    endfunction

    function automatic logic [5:0] model_out(input logic tm);
        logic [3:0] e;
        e = 4'((1 << m_on) - 1) | {4{tm}};
        return {e, (!m_ramp && m_on == N), m_ramp};
    endfunction

    task automatic check(input string nm, input logic [5:0] exp);
        logic [5:0] act;
        act = {bus.clk_en_o, bus.ack_o, bus.busy_o};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got en=%b ack=%b busy=%b, want en=%b ack=%b busy=%b",
                     nm, $time, act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] g, input logic t,
                        input logic [3:0] e, input logic a, input logic b, input string nm);
        @(negedge clk);
        bus.req_i = r; bus.cfg_gap_i = g; bus.test_mode_i = t;
        #1;
        check(nm, {e, a, b});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_i = 1'b0; bus.cfg_gap_i = 4'd0; bus.test_mode_i = 1'b0;

        // Test mode in OFF, then G=0 ramp with gap changed to 7 mid-ramp.
        add(1, 0, 0, 1, 4'b1111, 0, 0);
        add(1, 0, 0, 0, 4'b0000, 0, 0);
        add(1, 1, 0, 0, 4'b0000, 0, 0);
        add(1, 1, 7, 0, 4'b0001, 0, 1);
        add(1, 1, 7, 0, 4'b0011, 0, 1);
        add(1, 1, 7, 0, 4'b0111, 0, 1);
        add(1, 1, 7, 0, 4'b1111, 0, 1);
        add(2, 1, 7, 0, 4'b1111, 1, 0);
        add(1, 1, 2, 1, 4'b1111, 1, 0);
        // G=2 ramp down from ON.
        add(1, 0, 2, 0, 4'b1111, 1, 0);
        add(3, 0, 2, 0, 4'b0111, 0, 1);
        add(3, 0, 2, 0, 4'b0011, 0, 1);
        add(3, 0, 2, 0, 4'b0001, 0, 1);
        add(3, 0, 2, 0, 4'b0000, 0, 1);
        add(1, 0, 2, 0, 4'b0000, 0, 0);
        // G=2 ramp up from OFF.
        add(1, 1, 2, 0, 4'b0000, 0, 0);
        add(3, 1, 2, 0, 4'b0001, 0, 1);
        add(3, 1, 2, 0, 4'b0011, 0, 1);
        add(3, 1, 2, 0, 4'b0111, 0, 1);
        add(3, 1, 2, 0, 4'b1111, 0, 1);
        add(1, 1, 2, 0, 4'b1111, 1, 0);
        // Maximum gap on the way down, then reversal with G=0.
        add(1, 0, 15, 0, 4'b1111, 1, 0);
        add(16, 0, 0, 0, 4'b0111, 0, 1);
        add(1, 0, 0, 0, 4'b0011, 0, 1);
        add(1, 1, 0, 0, 4'b0011, 0, 1);
        add(1, 1, 0, 0, 4'b0111, 0, 1);
        add(1, 1, 0, 0, 4'b1111, 0, 1);
        add(1, 1, 0, 0, 4'b1111, 1, 0);
        // G=0 ramp down to OFF.
        add(1, 0, 0, 0, 4'b1111, 1, 0);
        add(1, 0, 0, 0, 4'b0111, 0, 1);
        add(1, 0, 0, 0, 4'b0011, 0, 1);
        add(1, 0, 0, 0, 4'b0001, 0, 1);
        add(1, 0, 0, 0, 4'b0000, 0, 1);
        add(1, 0, 0, 0, 4'b0000, 0, 0);

        #12;
        check("reset_state", 6'b0000_0_0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].req, tbl[i].gap, tbl[i].tm, tbl[i].en, tbl[i].ack, tbl[i].busy, $sformatf("vec%0d", i));

        // Abort when two domains are on, G=2.
        step(1, 2, 0, 4'b0000, 0, 0, "abort_c0");
        for (int i = 0; i < 3; i++) step(1, 2, 0, 4'b0001, 0, 1, "abort_up0");
        step(0, 2, 0, 4'b0011, 0, 1, "abort_drop");
        for (int i = 0; i < 3; i++) step(0, 2, 0, 4'b0001, 0, 1, "abort_down1");
        for (int i = 0; i < 3; i++) step(0, 2, 0, 4'b0000, 0, 1, "abort_down0");
        step(0, 2, 0, 4'b0000, 0, 0, "abort_off");

        // Reversal while ramping down at 0001.
        step(1, 2, 0, 4'b0000, 0, 0, "rev_c0");
        for (int i = 0; i < 3; i++) step(1, 2, 0, 4'b0001, 0, 1, "rev_up0");
        step(1, 2, 0, 4'b0011, 0, 1, "rev_up1");
        step(0, 2, 0, 4'b0011, 0, 1, "rev_drop");
        step(0, 2, 0, 4'b0001, 0, 1, "rev_down");
        step(1, 2, 0, 4'b0001, 0, 1, "rev_raise");
        for (int i = 0; i < 3; i++) step(1, 2, 0, 4'b0011, 0, 1, "rev_resume");
        step(1, 2, 0, 4'b0111, 0, 1, "rev_next");

        // Asynchronous reset mid-ramp, away from any clock edge.
        #2 rst_n = 1'b0;
        #1 check("arst_immediate", 6'b0000_0_0);
        @(posedge clk);
        step(1, 2, 0, 4'b0000, 0, 0, "arst_held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 2, 0, 4'b0001, 0, 1, "arst_restart0");
        step(1, 2, 0, 4'b0011, 0, 1, "arst_restart1");

        // Random run against the model.
        @(negedge clk);
        rst_n = 1'b0; bus.req_i = 1'b0; bus.test_mode_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(24) == 0) bus.req_i = ~bus.req_i;
            bus.cfg_gap_i   = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
            bus.test_mode_i = ($urandom_range(15) == 0);
            #1;
            check("random", model_out(bus.test_mode_i));
            @(posedge clk);
            model_edge(bus.req_i, bus.cfg_gap_i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
